// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
//
// Control unit for an RV32I single-cycle processor. It decodes the opcode,
// funct3 and funct7 bit 5 of the current instruction, together with the ALU
// zero flag, into the datapath control signals. All control outputs are purely
// combinational. The only state is a sticky debug flag that records whether an
// unsupported opcode has ever been decoded since the last reset.
//
// Ports:
//   i_clk        in   1  clock, used only by the sticky illegal-opcode flag
//   i_rst_n      in   1  asynchronous active-low reset (clears o_illegal)
//   i_op         in   7  instruction opcode [6:0]
//   i_funct3     in   3  instruction funct3 [14:12]
//   i_funct7b5   in   1  instruction bit 30
//   i_zero       in   1  ALU zero flag
//   o_alucrtl    out  3  ALU control: 000 add, 001 sub, 010 and, 011 or, 101 slt
//   o_resultsrc  out  2  result mux: 00 ALU, 01 memory, 10 PC+4
//   o_immsrc     out  2  immediate format: 00 I, 01 S, 10 B, 11 J
//   o_memwrite   out  1  data memory write enable
//   o_pcsrc      out  1  1 = PC+imm target, 0 = PC+4
//   o_alusrc     out  1  1 = immediate as ALU operand B, 0 = rs2
//   o_regwrite   out  1  register file write enable
//   o_jump       out  1  jump instruction flag
//   o_illegal    out  1  sticky unsupported-opcode flag
// -----------------------------------------------------------------------------
module controller (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic [2:0] o_alucrtl,
  output logic [1:0] o_resultsrc,
  output logic [1:0] o_immsrc,
  output logic       o_memwrite,
  output logic       o_pcsrc,
  output logic       o_alusrc,
  output logic       o_regwrite,
  output logic       o_jump,
  output logic       o_illegal
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic       branch;
  logic [1:0] aluop;
  logic       legal;

  // Main decoder. Unsupported opcodes leave every control low so that no
  // architectural state is modified and the PC simply advances.
  always_comb begin
    o_regwrite  = 1'b0;
    o_immsrc    = 2'b00;
    o_alusrc    = 1'b0;
    o_memwrite  = 1'b0;
    o_resultsrc = 2'b00;
    branch      = 1'b0;
    aluop       = 2'b00;
    o_jump      = 1'b0;
    legal       = 1'b1;
    case (i_op)
      OP_LW: begin
        o_regwrite  = 1'b1;
        o_alusrc    = 1'b1;
        o_resultsrc = 2'b01;
      end
      OP_SW: begin
        o_immsrc   = 2'b01;
        o_alusrc   = 1'b1;
        o_memwrite = 1'b1;
      end
      OP_RTYPE: begin
        o_regwrite = 1'b1;
        aluop      = 2'b10;
      end
      OP_BEQ: begin
        o_immsrc = 2'b10;
        branch   = 1'b1;
        aluop    = 2'b01;
      end
      OP_ITYPE: begin
        o_regwrite = 1'b1;
        o_alusrc   = 1'b1;
        aluop      = 2'b10;
      end
      OP_JAL: begin
        o_regwrite  = 1'b1;
        o_immsrc    = 2'b11;
        o_resultsrc = 2'b10;
        o_jump      = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // ALU decoder. Subtraction for funct3=000 needs both bit 30 and op[5]:
  // op[5] distinguishes R-type from I-type, so addi never turns into sub
  // even when its immediate happens to have bit 30 set.
  always_comb begin
    o_alucrtl = 3'b000;
    case (aluop)
      2'b01: o_alucrtl = 3'b001;
      2'b10: begin
        case (i_funct3)
          3'b000:  o_alucrtl = (i_op[5] & i_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  o_alucrtl = 3'b101;
          3'b110:  o_alucrtl = 3'b011;
          3'b111:  o_alucrtl = 3'b010;
          default: o_alucrtl = 3'b000;
        endcase
      end
      default: o_alucrtl = 3'b000;
    endcase
  end

  assign o_pcsrc = (branch & i_zero) | o_jump;

  // Sticky debug flag: once set it stays set until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_illegal <= 1'b0;
    end else if (!legal) begin
      o_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
//
// Self-checking bench for the RV32I controller. A table of instruction vectors
// with independently written expected control words is applied; each expected
// word is pushed to a scoreboard queue when the stimulus is driven and popped
// and compared once the combinational outputs have settled. Hand-written
// sequences then cover the sticky illegal-opcode flag and its async reset.
// -----------------------------------------------------------------------------
module tb_controller;

  logic       i_clk;
  logic       i_rst_n;
  logic [6:0] i_op;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic [2:0] o_alucrtl;
  logic [1:0] o_resultsrc;
  logic [1:0] o_immsrc;
  logic       o_memwrite;
  logic       o_pcsrc;
  logic       o_alusrc;
  logic       o_regwrite;
  logic       o_jump;
  logic       o_illegal;

  controller dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_op       (i_op),
    .i_funct3   (i_funct3),
    .i_funct7b5 (i_funct7b5),
    .i_zero     (i_zero),
    .o_alucrtl  (o_alucrtl),
    .o_resultsrc(o_resultsrc),
    .o_immsrc   (o_immsrc),
    .o_memwrite (o_memwrite),
    .o_pcsrc    (o_pcsrc),
    .o_alusrc   (o_alusrc),
    .o_regwrite (o_regwrite),
    .o_jump     (o_jump),
    .o_illegal  (o_illegal)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Control word: {alucrtl, resultsrc, immsrc, memwrite, pcsrc, alusrc, regwrite, jump}
  logic [11:0] act;
  assign act = {o_alucrtl, o_resultsrc, o_immsrc, o_memwrite, o_pcsrc,
                o_alusrc, o_regwrite, o_jump};

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [11:0] exp;
  } sb_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[16];
  sb_t  sb_q[$];

  function automatic vec_t mk(input string name, input logic [6:0] op,
                              input logic [2:0] f3, input logic f7, input logic z,
                              input logic [2:0] alu, input logic [1:0] res,
                              input logic [1:0] imm, input logic mw, input logic pc,
                              input logic as, input logic rw, input logic j);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.f3   = f3;
    v.f7   = f7;
    v.z    = z;
    v.exp  = {alu, res, imm, mw, pc, as, rw, j};
    return v;
  endfunction

  task automatic drive(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [11:0] exp);
    sb_t e;
    i_op       = op;
    i_funct3   = f3;
    i_funct7b5 = f7;
    i_zero     = z;
    e.name     = name;
    e.exp      = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_ctrl();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("FAIL %s: got ctrl %b, expected %b", e.name, act, e.exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  initial begin
    //                 name          op          f3     f7    z     alu     res    imm    mw    pc    as    rw    j
    tbl[0]  = mk("lw",          7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[1]  = mk("sw",          7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk("r_add",       7'b0110011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk("r_sub",       7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk("r_slt",       7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk("r_or",        7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk("r_and",       7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk("r_f3_001",    7'b0110011, 3'b001, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk("beq_taken",   7'b1100011, 3'b000, 1'b0, 1'b1, 3'b001, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk("beq_not",     7'b1100011, 3'b000, 1'b0, 1'b0, 3'b001, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk("beq_f3_odd",  7'b1100011, 3'b111, 1'b1, 1'b1, 3'b001, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk("addi",        7'b0010011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[12] = mk("addi_b30",    7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[13] = mk("ori",         7'b0010011, 3'b110, 1'b1, 1'b0, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[14] = mk("jal",         7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, 2'b10, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tbl[15] = mk("lw_zero1",    7'b0000011, 3'b010, 1'b0, 1'b1, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset with a legal op on the bus so nothing can set the flag.
    i_rst_n    = 1'b0;
    i_op       = 7'b0000011;
    i_funct3   = 3'b010;
    i_funct7b5 = 1'b0;
    i_zero     = 1'b0;
    #1;
    check_bit("reset_illegal", o_illegal, 1'b0);

    // Control outputs do not depend on reset.
    @(negedge i_clk);
    drive("jal_in_reset", 7'b1101111, 3'b000, 1'b0, 1'b0,
          {3'b000, 2'b10, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
    #1;
    check_ctrl();

    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      drive(tbl[i].name, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].exp);
      #1;
      check_ctrl();
    end
    @(posedge i_clk);
    #1;
    check_bit("legal_ops_no_illegal", o_illegal, 1'b0);

    // Unsupported opcode: all controls low, flag set after the edge.
    @(negedge i_clk);
    drive("illegal_ctrl", 7'b1111111, 3'b000, 1'b1, 1'b1, 12'b0);
    #1;
    check_ctrl();
    check_bit("illegal_before_edge", o_illegal, 1'b0);
    @(posedge i_clk);
    #1;
    check_bit("illegal_set", o_illegal, 1'b1);

    // Legal op afterwards: flag holds.
    @(negedge i_clk);
    drive("sw_after_illegal", 7'b0100011, 3'b010, 1'b0, 1'b0,
          {3'b000, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    #1;
    check_ctrl();
    repeat (2) @(posedge i_clk);
    #1;
    check_bit("illegal_sticky", o_illegal, 1'b1);

    // Asynchronous reset mid-cycle clears it without a clock edge.
    #2;
    i_rst_n = 1'b0;
    #1;
    check_bit("async_clear", o_illegal, 1'b0);

    // Held in reset, an illegal op across an edge must not set it.
    @(negedge i_clk);
    drive("illegal_in_reset", 7'b0000000, 3'b000, 1'b0, 1'b0, 12'b0);
    #1;
    check_ctrl();
    @(posedge i_clk);
    #1;
    check_bit("reset_dominates", o_illegal, 1'b0);

    // Release with a legal op: stays clear.
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive("beq_after_reset", 7'b1100011, 3'b000, 1'b0, 1'b1,
          {3'b001, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    #1;
    check_ctrl();
    @(posedge i_clk);
    #1;
    check_bit("clear_after_release", o_illegal, 1'b0);

    // Near-miss opcode (jalr, not supported) also flags.
    @(negedge i_clk);
    drive("jalr_unsupported", 7'b1100111, 3'b000, 1'b0, 1'b1, 12'b0);
    #1;
    check_ctrl();
    @(posedge i_clk);
    #1;
    check_bit("jalr_sets_illegal", o_illegal, 1'b1);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
